// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory bus arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int DEFAULT_TIMEOUT = 5;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin pick
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    // On a tie the requester that did not win last time goes next.
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory_controller port between CPU and DMA masters
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [1:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  input  logic                    mem_error,
  output logic                    owner,
  output logic                    busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  generate
    if (TIMEOUT < 1) begin : g_timeout_check
      $error("mem_bus_arbiter: TIMEOUT must be >= 1");
    end
  endgenerate

  arb_state_t      state;
  logic            last;
  logic [CW-1:0]   cnt;
  logic            pick_valid;
  logic            pick_winner;

  rr_pick2 u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ack       <= 2'b00;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= REQ_CPU;
      busy      <= 1'b0;
      last      <= REQ_DMA;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 2'b00;
          if (pick_valid) begin
            owner     <= pick_winner;
            mem_we    <= pick_winner ? we[1] : we[0];
            mem_addr  <= pick_winner ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
            mem_wdata <= pick_winner ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
            cnt       <= '0;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          cnt <= cnt + CW'(1);
          if (mem_ready || mem_error) begin
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
            err     <= mem_error;
            mem_req <= 1'b0;
            ack     <= (owner == REQ_DMA) ? 2'b10 : 2'b01;
            state   <= RESP;
          end else if (cnt == CNT_LAST) begin
            // Watchdog expiry: complete with error, leave rdata untouched.
            err     <= 1'b1;
            mem_req <= 1'b0;
            ack     <= (owner == REQ_DMA) ? 2'b10 : 2'b01;
            state   <= RESP;
          end
        end

        RESP: begin
          ack   <= 2'b00;
          last  <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          ack     <= 2'b00;
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
